div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle divider sequencer for the EX stage. It accepts DIV/DIVU operands, runs a 32-iteration restoring division, and holds the pipeline through a stall request until the {HI, LO} result is ready. EX forwards the result into the hi/lo write fields that travel through MEM and WB. The stall request feeds the pipeline stall controller that drives the stage `stall` bus.

## Interface
Parameters:
- none. Width is fixed at 32-bit operands and a 64-bit result.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start_i  in  1  EX requests a division. Held high by EX while stalled.
- signed_i  in  1  1 = DIV (signed), 0 = DIVU. Sampled with start_i.
- opdata1_i  in  32  dividend. Sampled on acceptance.
- opdata2_i  in  32  divisor. Sampled on acceptance.
- annul_i  in  1  cancel (exception/flush). Aborts any operation in flight.
- result_o  out  64  {remainder → HI [63:32], quotient → LO [31:0]}. Registered.
- ready_o  out  1  one-cycle pulse; result_o is valid this cycle.
- stallreq_o  out  1  combinational stall request to the stall controller.

## Operation
- FSM states: IDLE, DIVZERO, ON, END.
- IDLE:
  - If start_i && !annul_i: latch operands and signed_i.
  - If divisor == 0, go to DIVZERO.
  - Otherwise go to ON with cnt = 0. Load work register W[64:0] = {32'b0, |dividend|, 1'b0}. Latch |divisor|.
  - When signed_i = 0, absolute value means the raw operand.
- ON, one iteration per cycle:
  - Compute diff = W[64:32] − {1'b0, |divisor|}, 33 bits.
  - If diff[32] = 0: W ← {diff[31:0], W[31:0], 1'b1}.
  - Else: W ← {W[63:0], 1'b0}.
  - cnt increments. At the end of the cnt = 31 iteration, go to END.
  - Final quotient = W[31:0]. Final remainder = W[64:33].
- Sign fix, applied on entry to END when signed:
  - Quotient is negated (two's complement) if the dividend and divisor signs differ.
  - Remainder is negated if the dividend is negative.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (natural wrap).
- DIVZERO: load result_o ← 64'b0, then go to END next cycle.
- END: ready_o = 1. Always returns to IDLE next cycle, regardless of start_i.
- result_o is written only on entry to END and holds its value otherwise.
- annul_i:
  - In DIVZERO or ON, the next state is IDLE. No ready_o, and result_o is unchanged.
  - In IDLE, it blocks acceptance.
  - In END, it has no effect (ready_o still pulses).
- stallreq_o = (IDLE && start_i && !annul_i) || ON || DIVZERO. It is low in END, so EX advances and captures result_o.

## Timing
- Reset (resetn = 0, asynchronous): state = IDLE, cnt = 0, W = 0, result_o = 0, ready_o = 0. stallreq_o = 0 unless start_i is high.
- Reset mid-operation aborts immediately. After release, the block is in IDLE.
- Latency from the acceptance edge (cycle 0 = cycle where IDLE sees start_i):
  - Nonzero divisor: ON occupies cycles 1..32; END/ready_o in cycle 33.
  - Zero divisor: DIVZERO in cycle 1, END in cycle 2.
- stallreq_o is high in cycles 0..32 (or 0..1 for a zero divisor) and low in the ready_o cycle.
- Back-to-back divides:
  - END → IDLE takes one cycle.
  - If start_i is high in that IDLE cycle (the next instruction is a divide), it is accepted there.
  - Throughput: 34 cycles per divide.
- Operand changes on opdata*_i after acceptance are ignored.
- start_i dropping while in ON does not abort; only annul_i or reset aborts.

## Test plan
- Unsigned 100 / 7:
  - Stimulus: start_i = 1, signed_i = 0, held until ready.
  - Response: ready_o at cycle 33; result_o = {32'd2, 32'd14}; stallreq_o high in cycles 0..32.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002):
  - Response: result_o = {0xFFFFFFFF, 0xFFFFFFFD}.
  - Also cover 7 / −2, which gives {0x00000001, 0xFFFFFFFD}.
- Divide by zero (0x1234 / 0):
  - Response: ready_o in cycle 2; result_o = 64'b0; stallreq_o high in cycles 0..1 only.
- Annul in ON:
  - Stimulus: start a divide, pulse annul_i in cycle 10.
  - Response: IDLE in cycle 11; no ready_o; result_o keeps its previous value; stallreq_o low once start_i drops.
- Back-to-back:
  - Stimulus: 0xFFFFFFFF / 0x10 unsigned, then 0x80000000 / 0xFFFFFFFF signed, with start_i high continuously.
  - Response: results {0xF, 0x0FFFFFFF} at cycle 33 and {0x0, 0x80000000} at cycle 67.
- Asynchronous reset mid-division:
  - Stimulus: drop resetn in cycle 15, off a clock edge.
  - Response: outputs go to reset values immediately. The next divide after release completes normally with correct latency.

Source files
------------

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
//
// Multi-cycle divider sequencer for the EX stage.
//
// It accepts DIV/DIVU operands and runs a 32-iteration restoring division,
// producing one quotient bit per cycle. While it works, it holds the pipeline
// through a stall request. The {HI, LO} = {remainder, quotient} result is
// registered. It is presented together with a one-cycle ready pulse in the
// END state.
//
// Ports
//   clk         in   1   pipeline clock, rising-edge active
//   resetn      in   1   asynchronous active-low reset
//   start_i     in   1   EX requests a division (held high while stalled)
//   signed_i    in   1   1 = DIV (signed), 0 = DIVU; sampled with start_i
//   opdata1_i   in   32  dividend, sampled on acceptance
//   opdata2_i   in   32  divisor, sampled on acceptance
//   annul_i     in   1   flush/exception; aborts an operation in flight
//   result_o    out  64  {remainder, quotient}, registered
//   ready_o     out  1   one-cycle pulse, result_o valid this cycle
//   stallreq_o  out  1   combinational stall request to the stall controller
// -----------------------------------------------------------------------------
module div_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIVZERO = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_END     = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [4:0]  cnt;
  logic [64:0] work;
  logic [31:0] divisor_abs;
  logic        signed_op;
  logic        dividend_neg;
  logic        divisor_neg;

  logic        accept;
  logic        last_iter;
  logic [31:0] dividend_abs_in;
  logic [31:0] divisor_abs_in;
  logic [32:0] diff;
  logic [64:0] work_step;
  logic [31:0] quot_raw;
  logic [31:0] rem_raw;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // A new operation is accepted only from IDLE, and only when not flushed.
  assign accept    = (state == S_IDLE) && start_i && !annul_i;
  assign last_iter = (cnt == 5'd31);

  // Operand magnitudes. For DIVU the raw operands are used unchanged. Negating
  // 0x80000000 wraps back to 0x80000000, which is the correct unsigned
  // magnitude.
  always_comb begin
    dividend_abs_in = opdata1_i;
    divisor_abs_in  = opdata2_i;
    if (signed_i && opdata1_i[31]) begin
      dividend_abs_in = ~opdata1_i + 32'd1;
    end
    if (signed_i && opdata2_i[31]) begin
      divisor_abs_in = ~opdata2_i + 32'd1;
    end
  end

  // One restoring-division step. The top 33 bits of the work register hold
  // the partial remainder with the next dividend bit already shifted in. A
  // non-negative difference means the subtraction succeeds: the difference
  // replaces the remainder and a 1 is shifted into the quotient. Otherwise
  // the register shifts left and a 0 is shifted in. After 32 steps the
  // quotient sits in [31:0] and the remainder in [64:33].
  always_comb begin
    diff = work[64:32] - {1'b0, divisor_abs};
    if (!diff[32]) begin
      work_step = {diff[31:0], work[31:0], 1'b1};
    end else begin
      work_step = {work[63:0], 1'b0};
    end
  end

  // Sign correction for DIV is applied to the final step's outcome. This lets
  // the corrected result be registered on the same edge that enters END. The
  // quotient is negative when the operand signs differ. The remainder takes
  // the sign of the dividend.
  always_comb begin
    quot_raw = work_step[31:0];
    rem_raw  = work_step[64:33];
    quot_fix = quot_raw;
    rem_fix  = rem_raw;
    if (signed_op && (dividend_neg ^ divisor_neg)) begin
      quot_fix = ~quot_raw + 32'd1;
    end
    if (signed_op && dividend_neg) begin
      rem_fix = ~rem_raw + 32'd1;
    end
  end

  // Next-state logic. A flush abandons DIVZERO and ON without a ready pulse.
  // END always drains back to IDLE for one cycle, even if EX already holds
  // the next divide on start_i.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = (opdata2_i == 32'd0) ? S_DIVZERO : S_ON;
        end
      end
      S_DIVZERO: begin
        state_next = annul_i ? S_IDLE : S_END;
      end
      S_ON: begin
        if (annul_i) begin
          state_next = S_IDLE;
        end else if (last_iter) begin
          state_next = S_END;
        end
      end
      S_END: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers. Operands are captured once, at acceptance, so later
  // changes on opdata*_i cannot disturb a division in progress. result_o is
  // written only on the edge that enters END. It keeps its value through
  // aborts and idle periods.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt          <= 5'd0;
      work         <= 65'd0;
      divisor_abs  <= 32'd0;
      signed_op    <= 1'b0;
      dividend_neg <= 1'b0;
      divisor_neg  <= 1'b0;
      result_o     <= 64'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            signed_op    <= signed_i;
            dividend_neg <= signed_i & opdata1_i[31];
            divisor_neg  <= signed_i & opdata2_i[31];
            divisor_abs  <= divisor_abs_in;
            work         <= {32'd0, dividend_abs_in, 1'b0};
            cnt          <= 5'd0;
          end
        end
        S_DIVZERO: begin
          if (!annul_i) begin
            result_o <= 64'd0;
          end
        end
        S_ON: begin
          if (!annul_i) begin
            work <= work_step;
            cnt  <= cnt + 5'd1;
            if (last_iter) begin
              result_o <= {rem_fix, quot_fix};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready_o = (state == S_END);

  // The stall request is low in END, so EX advances and captures result_o.
  assign stallreq_o = accept || (state == S_ON) || (state == S_DIVZERO);

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq
//
// Directed bench for div_seq. Expected results are pushed onto a scoreboard
// queue when a divide is started. They are popped and compared when ready_o
// pulses. Latency and the stall request are tracked cycle by cycle, relative
// to the acceptance cycle.
// -----------------------------------------------------------------------------
module tb_div_seq;

  logic        clk;
  logic        resetn;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int          tests;
  int          fails;
  logic [63:0] sb[$];
  logic [63:0] last_result;

  div_seq dut (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to two time units after the next rising edge. Checks and input
  // changes both happen at this point.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts a divide in the current (IDLE) cycle, which is cycle 0. It pushes
  // the expected result and follows the operation to its ready pulse. The
  // operands are scrambled after acceptance. start_i is left high when keep
  // is set, for back-to-back issue.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic sgn, input logic [63:0] exp_res,
                               input int exp_lat, input logic keep);
    logic done;
    checkOutput({tag, "_hold"}, result_o, last_result);
    start_i   = 1'b1;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    sb.push_back(exp_res);
    #1;
    checkOutput({tag, "_stall_c0"}, {63'd0, stallreq_o}, 64'd1);
    checkOutput({tag, "_ready_c0"}, {63'd0, ready_o}, 64'd0);
    done = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      tick();
      if (cyc == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~sgn;
      end
      if (ready_o) begin
        done = 1'b1;
        checkOutput({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        checkOutput({tag, "_stall_end"}, {63'd0, stallreq_o}, 64'd0);
        if (sb.size() == 0) begin
          checkOutput({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
          checkOutput({tag, "_result"}, result_o, sb.pop_front());
        end
        last_result = exp_res;
      end else if (cyc < exp_lat) begin
        checkOutput({tag, "_stall"}, {63'd0, stallreq_o}, 64'd1);
      end
    end
    if (!done) begin
      checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
      sb.delete();
    end
    if (!keep) begin
      start_i = 1'b0;
    end
  endtask

  initial begin
    logic seen;
    tests       = 0;
    fails       = 0;
    last_result = 64'd0;
    resetn      = 1'b0;
    start_i     = 1'b0;
    signed_i    = 1'b0;
    opdata1_i   = 32'd0;
    opdata2_i   = 32'd0;
    annul_i     = 1'b0;

    // Reset state
    #1;
    checkOutput("rst_result", result_o, 64'd0);
    checkOutput("rst_ready", {63'd0, ready_o}, 64'd0);
    checkOutput("rst_stall", {63'd0, stallreq_o}, 64'd0);
    #11 resetn = 1'b1;

    // Basic unsigned, zero divisor, and signed cases
    tick();
    applyStimulus("udiv_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 1'b0);
    tick();
    applyStimulus("divzero", 32'h1234, 32'd0, 1'b0, 64'd0, 2, 1'b0);
    tick();
    applyStimulus("sdiv_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0);
    tick();
    applyStimulus("sdiv_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 33, 1'b0);
    tick();
    applyStimulus("sdiv_m100_7", 32'hFFFFFF9C, 32'd7, 1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, 1'b0);

    // Annul while ON: cycle 10 carries the flush, and cycle 11 is back in IDLE
    tick();
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    for (int i = 1; i <= 10; i++) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    #1;
    checkOutput("annul_on_stall_c10", {63'd0, stallreq_o}, 64'd1);
    tick();
    annul_i = 1'b0;
    #1;
    checkOutput("annul_on_stall_c11", {63'd0, stallreq_o}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen |= ready_o;
    end
    checkOutput("annul_on_no_ready", {63'd0, seen}, 64'd0);
    checkOutput("annul_on_result", result_o, last_result);

    // Annul in IDLE blocks acceptance
    start_i   = 1'b1;
    annul_i   = 1'b1;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    #1;
    checkOutput("annul_idle_stall", {63'd0, stallreq_o}, 64'd0);
    tick();
    tick();
    start_i = 1'b0;
    annul_i = 1'b0;
    seen    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen |= ready_o;
    end
    checkOutput("annul_idle_no_ready", {63'd0, seen}, 64'd0);

    // Back-to-back: the second result arrives at cycle 67 from the first
    // acceptance
    tick();
    applyStimulus("b2b_first", 32'hFFFFFFFF, 32'h10, 1'b0, {32'h0000000F, 32'h0FFFFFFF}, 33, 1'b1);
    tick();
    applyStimulus("b2b_second", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h00000000, 32'h80000000}, 33, 1'b0);

    // Asynchronous reset in cycle 15, off the clock edge
    tick();
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'h12345678;
    opdata2_i = 32'h100;
    sb.push_back({32'h78, 32'h00123456});
    for (int i = 1; i <= 15; i++) tick();
    #4;
    resetn  = 1'b0;
    start_i = 1'b0;
    #1;
    checkOutput("arst_result", result_o, 64'd0);
    checkOutput("arst_ready", {63'd0, ready_o}, 64'd0);
    checkOutput("arst_stall", {63'd0, stallreq_o}, 64'd0);
    sb.delete();
    last_result = 64'd0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    applyStimulus("post_rst", 32'hFFFFFFFF, 32'd3, 1'b0, {32'd0, 32'h55555555}, 33, 1'b0);
    tick();
    checkOutput("final_hold", result_o, last_result);
    checkOutput("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
